// File: rtl/taillight_pkg.sv
// Shared types and lamp patterns for the tail-light sequencer.
package taillight_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StL1,
    StL2,
    StL3,
    StR1,
    StR2,
    StR3,
    StHOn,
    StHOff
  } state_t;

  // Bit order {la, lb, lc, ra, rb, rc}; la/ra are the innermost lamps.
  typedef logic [5:0] lamps_t;

  localparam lamps_t PAT_OFF   = 6'b000_000;
  localparam lamps_t PAT_L1    = 6'b100_000;
  localparam lamps_t PAT_L2    = 6'b110_000;
  localparam lamps_t PAT_L3    = 6'b111_000;
  localparam lamps_t PAT_R1    = 6'b000_100;
  localparam lamps_t PAT_R2    = 6'b000_110;
  localparam lamps_t PAT_R3    = 6'b000_111;
  localparam lamps_t PAT_LEFT  = 6'b111_000;
  localparam lamps_t PAT_RIGHT = 6'b000_111;
  localparam lamps_t PAT_ALL   = 6'b111_111;

endpackage

// File: rtl/taillight_seq_ctrl_tick_gen.sv
// Step-rate prescaler: pulses tick every TICK_DIV cycles, restarted by clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Wrap on tick so a non-power-of-two divider keeps its period while idling.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/taillight_seq_ctrl.sv
// Tail-light controller: arbitrates turn/hazard requests, steps lamps at a
// prescaled rate and overlays the brake lamps.
module taillight_seq_ctrl
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy
);

  state_t state_q, state_d;
  logic   tick;
  logic   state_chg;
  logic   hz_req;
  lamps_t pat;
  lamps_t overlay;
  lamps_t lamps;

  assign hz_req    = hazard | (left & right);
  assign state_chg = (state_d != state_q);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hz_req) begin
          state_d = StHOn;
        end else if (left) begin
          state_d = StL1;
        end else if (right) begin
          state_d = StR1;
        end
      end
      StL1:   if (tick) state_d = hz_req ? StHOn : StL2;
      StL2:   if (tick) state_d = hz_req ? StHOn : StL3;
      StL3:   if (tick) state_d = hz_req ? StHOn : StIdle;
      StR1:   if (tick) state_d = hz_req ? StHOn : StR2;
      StR2:   if (tick) state_d = hz_req ? StHOn : StR3;
      StR3:   if (tick) state_d = hz_req ? StHOn : StIdle;
      StHOn:  if (tick) state_d = StHOff;
      StHOff: if (tick) state_d = hz_req ? StHOn : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pat     = PAT_OFF;
    overlay = PAT_OFF;
    unique case (state_q)
      StIdle: overlay = brake ? PAT_ALL : PAT_OFF;
      StL1: begin
        pat     = PAT_L1;
        overlay = brake ? PAT_RIGHT : PAT_OFF;
      end
      StL2: begin
        pat     = PAT_L2;
        overlay = brake ? PAT_RIGHT : PAT_OFF;
      end
      StL3: begin
        pat     = PAT_L3;
        overlay = brake ? PAT_RIGHT : PAT_OFF;
      end
      StR1: begin
        pat     = PAT_R1;
        overlay = brake ? PAT_LEFT : PAT_OFF;
      end
      StR2: begin
        pat     = PAT_R2;
        overlay = brake ? PAT_LEFT : PAT_OFF;
      end
      StR3: begin
        pat     = PAT_R3;
        overlay = brake ? PAT_LEFT : PAT_OFF;
      end
      StHOn:  pat = PAT_ALL;
      StHOff: pat = PAT_OFF;
      default: pat = PAT_OFF;
    endcase
  end

  // Reset blanks the lamps immediately, before the state register clears.
  assign lamps = reset ? PAT_OFF : (pat | overlay);
  assign {la, lb, lc, ra, rb, rc} = lamps;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Self-checking bench for taillight_seq_ctrl with an abstract lamp model.
module tb_taillight_seq_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic la, lb, lc, ra, rb, rc, busy;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 left, 2 right, 3 hazard; step = lamps lit (turn) or on/off (hazard).
  int m_mode = 0;
  int m_step = 0;
  int m_age  = 0;

  taillight_seq_ctrl #(
    .TICK_DIV (DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .la     (la),
    .lb     (lb),
    .lc     (lc),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_lamps();
    int nl, nr;
    logic [5:0] v;
    nl = (m_mode == 1) ? m_step : ((m_mode == 3 && m_step == 1) ? 3 : 0);
    nr = (m_mode == 2) ? m_step : ((m_mode == 3 && m_step == 1) ? 3 : 0);
    if (brake) begin
      if (m_mode == 0) begin
        nl = 3;
        nr = 3;
      end else if (m_mode == 1) begin
        nr = 3;
      end else if (m_mode == 2) begin
        nl = 3;
      end
    end
    v = {nl >= 1, nl >= 2, nl >= 3, nr >= 1, nr >= 2, nr >= 3};
    if (reset) v = 6'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    bit hz, tk;
    hz = hazard | (left & right);
    tk = (m_age == DIV - 1);
    if (reset) begin
      m_mode = 0;
      m_step = 0;
      m_age  = 0;
    end else if (m_mode == 0) begin
      m_age = 0;
      if (hz) begin
        m_mode = 3;
        m_step = 1;
      end else if (left) begin
        m_mode = 1;
        m_step = 1;
      end else if (right) begin
        m_mode = 2;
        m_step = 1;
      end
    end else if (!tk) begin
      m_age++;
    end else begin
      m_age = 0;
      if (m_mode == 3) begin
        if (m_step == 1) m_step = 0;
        else if (hz) m_step = 1;
        else m_mode = 0;
      end else if (hz) begin
        m_mode = 3;
        m_step = 1;
      end else if (m_step == 3) begin
        m_mode = 0;
        m_step = 0;
      end else begin
        m_step++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({la, lb, lc, ra, rb, rc} !== model_lamps() || busy !== (m_mode != 0)) begin
        n_fail++;
        $display("FAIL model t=%0t lamps=%b busy=%b expected lamps=%b busy=%b", $time,
                 {la, lb, lc, ra, rb, rc}, busy, model_lamps(), m_mode != 0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [5:0] exp_l, input logic exp_b);
    n_chk++;
    if ({la, lb, lc, ra, rb, rc} !== exp_l || busy !== exp_b) begin
      n_fail++;
      $display("FAIL %s lamps=%b busy=%b expected lamps=%b busy=%b", name,
               {la, lb, lc, ra, rb, rc}, busy, exp_l, exp_b);
    end
  endtask

  initial begin
    step(2);
    chk_en = 1'b1;
    check("reset_state", 6'b000000, 1'b0);
    reset = 1'b0;

    // 1: left pulse
    left = 1'b1;
    step();
    left = 1'b0;
    check("t1_l1", 6'b100000, 1'b1);
    step(4); check("t1_l2", 6'b110000, 1'b1);
    step(4); check("t1_l3", 6'b111000, 1'b1);
    step(4); check("t1_idle", 6'b000000, 1'b0);

    // 2: right held
    right = 1'b1;
    step();  check("t2_r1", 6'b000100, 1'b1);
    step(4); check("t2_r2", 6'b000110, 1'b1);
    step(4); check("t2_r3", 6'b000111, 1'b1);
    step(4); check("t2_idle", 6'b000000, 1'b0);
    step();  check("t2_restart", 6'b000100, 1'b1);
    right = 1'b0;
    step(12); check("t2_done", 6'b000000, 1'b0);
    step(2);

    // 3: left & right -> hazard flashing
    left  = 1'b1;
    right = 1'b1;
    step();  check("t3_on", 6'b111111, 1'b1);
    step(4); check("t3_off", 6'b000000, 1'b1);
    step(4); check("t3_on2", 6'b111111, 1'b1);
    left  = 1'b0;
    right = 1'b0;
    step(4); check("t3_off2", 6'b000000, 1'b1);
    step(4); check("t3_idle", 6'b000000, 1'b0);

    // 4: brake overlay
    brake = 1'b1;
    step();  check("t4_idle_brake", 6'b111111, 1'b0);
    left = 1'b1;
    step();
    left = 1'b0;
    check("t4_l1", 6'b100111, 1'b1);
    step(4); check("t4_l2", 6'b110111, 1'b1);
    step(4); check("t4_l3", 6'b111111, 1'b1);
    step(4); check("t4_idle", 6'b111111, 1'b0);
    brake = 1'b0;
    step();

    // 5: hazard preempts a right sequence
    right = 1'b1;
    step();
    right = 1'b0;
    step(4); check("t5_r2", 6'b000110, 1'b1);
    hazard = 1'b1;
    step(3); check("t5_r2_hold", 6'b000110, 1'b1);
    step();  check("t5_hon", 6'b111111, 1'b1);
    hazard = 1'b0;
    step(4); check("t5_hoff", 6'b000000, 1'b1);
    step(4); check("t5_idle", 6'b000000, 1'b0);

    // 6: reset mid-sequence with brake held
    left = 1'b1;
    step();
    left = 1'b0;
    step(4);
    brake = 1'b1;
    #1; check("t6_l2_brake", 6'b110111, 1'b1);
    reset = 1'b1;
    #1; check("t6_reset_blank", 6'b000000, 1'b1);
    step();  check("t6_reset_idle", 6'b000000, 1'b0);
    reset = 1'b0;
    #1; check("t6_release", 6'b111111, 1'b0);
    brake = 1'b0;
    left = 1'b1;
    step();
    left = 1'b0;
    check("t6_l1", 6'b100000, 1'b1);
    step(3); check("t6_l1_hold", 6'b100000, 1'b1);
    step();  check("t6_l2", 6'b110000, 1'b1);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
